// File: rtl/bram_capture_writer.sv
// -----------------------------------------------------------------------------
// bram_capture_writer
//
// Purpose:
//   On a rising edge of the asynchronous capture_trig level, stores a burst of
//   MAX_ADDR/ADDR_STEP samples from a valid-qualified stream into a BRAM port.
//   Addresses are byte addresses starting at 0 and stepping by ADDR_STEP. The
//   filled BRAM is the source memory drained by the downstream copy logic;
//   busy/done/word_count are read by the PS through the register block.
//
// Stream handshake:
//   s_valid qualifies s_data in the cycle it is high. There is no ready: the
//   block accepts every valid sample while capturing and ignores the stream
//   otherwise (idle or done).
//
// Ports:
//   clk           in   capture clock, all logic on the rising edge
//   rst           in   asynchronous active-high reset
//   capture_trig  in   asynchronous trigger level; rising edge starts a capture
//   s_data        in   sample word
//   s_valid       in   s_data valid this cycle
//   bram_addr     out  BRAM byte address of the presented write
//   bram_din      out  BRAM write data
//   bram_en       out  BRAM enable, always 1
//   bram_we       out  one-cycle write pulse per stored word
//   busy          out  high while capturing
//   done          out  high from capture completion until the next trigger
//   word_count    out  words written in the current or last capture
//   dbg_state     out  FSM state (0 idle, 1 capture, 2 done) for observation
// -----------------------------------------------------------------------------
module bram_capture_writer #(
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] MAX_ADDR  = 32'd8192,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_trig,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic [31:0]       bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_en,
    output logic              bram_we,
    output logic              busy,
    output logic              done,
    output logic [31:0]       word_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [31:0] STEP      = 32'(ADDR_STEP);
    // Address of the final word; its write ends the capture.
    localparam logic [31:0] LAST_ADDR = MAX_ADDR - STEP;

    state_t      state;
    logic [31:0] wr_ptr;

    // Trigger synchronizer. trig_r1 is the metastability-catching flop; the
    // edge is taken between the two later, settled stages.
    logic trig_r1;
    logic trig_r2;
    logic trig_r3;
    logic trig_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_r1 <= 1'b0;
            trig_r2 <= 1'b0;
            trig_r3 <= 1'b0;
        end else begin
            trig_r1 <= capture_trig;
            trig_r2 <= trig_r1;
            trig_r3 <= trig_r2;
        end
    end

    assign trig_edge = trig_r2 & ~trig_r3;

    // The port is never idle-gated; writes are qualified by bram_we alone.
    assign bram_en   = 1'b1;
    assign dbg_state = state;

    // Capture FSM with registered outputs. bram_we defaults low every cycle so
    // each stored word produces exactly one pulse; address and data hold
    // between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= 32'd0;
            bram_addr  <= 32'd0;
            bram_din   <= '0;
            bram_we    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= 32'd0;
        end else begin
            bram_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (trig_edge) begin
                        state      <= ST_CAPTURE;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        wr_ptr     <= 32'd0;
                        word_count <= 32'd0;
                    end
                end
                ST_CAPTURE: begin
                    // Trigger edges are ignored here: no restart mid-burst.
                    if (s_valid) begin
                        bram_addr  <= wr_ptr;
                        bram_din   <= s_data;
                        bram_we    <= 1'b1;
                        wr_ptr     <= wr_ptr + STEP;
                        word_count <= word_count + 32'd1;
                        // The final write is still presented next cycle while
                        // busy drops and done rises on the same edge.
                        if (wr_ptr == LAST_ADDR) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_capture_writer.sv
// -----------------------------------------------------------------------------
// tb_bram_capture_writer
//
// Two instances share one stimulus stream: the default 8192-byte region and a
// 16-byte region. A transaction-level model predicts, per edge, whether a word
// is stored, where, and the status flags; every cycle the outputs are compared
// and each presented write is matched against an expected-write queue.
// -----------------------------------------------------------------------------
module tb_bram_capture_writer;

    localparam int BIG_WORDS   = 2048;
    localparam int SMALL_WORDS = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        capture_trig;
    logic        s_valid;
    logic [31:0] s_data;

    always #5 clk = ~clk;

    logic [31:0] addr_b, din_b, wc_b;
    logic        en_b, we_b, busy_b, done_b;
    logic [1:0]  st_b;
    logic [31:0] addr_s, din_s, wc_s;
    logic        en_s, we_s, busy_s, done_s;
    logic [1:0]  st_s;

    bram_capture_writer u_big (
        .clk(clk), .rst(rst), .capture_trig(capture_trig),
        .s_data(s_data), .s_valid(s_valid),
        .bram_addr(addr_b), .bram_din(din_b), .bram_en(en_b), .bram_we(we_b),
        .busy(busy_b), .done(done_b), .word_count(wc_b), .dbg_state(st_b)
    );

    bram_capture_writer #(.MAX_ADDR(32'd16)) u_small (
        .clk(clk), .rst(rst), .capture_trig(capture_trig),
        .s_data(s_data), .s_valid(s_valid),
        .bram_addr(addr_s), .bram_din(din_s), .bram_en(en_s), .bram_we(we_s),
        .busy(busy_s), .done(done_s), .word_count(wc_s), .dbg_state(st_s)
    );

    // ---------------- reference model ----------------
    int          m_depth [2];
    bit          m_active[2];
    bit          m_done  [2];
    int          m_cnt   [2];
    bit          m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_din   [2];
    // Trigger level as sampled on the last three edges (h0 most recent).
    bit          h0, h1, h2;
    logic [63:0] exp_q_big[$];
    logic [63:0] exp_q_small[$];

    int n_total = 0;
    int n_bad   = 0;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_done[i]   = 1'b0;
            m_cnt[i]    = 0;
            m_we[i]     = 1'b0;
            m_addr[i]   = 32'd0;
            m_din[i]    = 32'd0;
        end
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
        exp_q_big.delete();
        exp_q_small.delete();
    endfunction

    // One clock edge: a rise seen two edges ago (and not three) starts a
    // capture if none is running; a running capture stores each valid sample.
    function automatic void model_edge();
        bit fire;
        fire = h1 & ~h2;
        for (int i = 0; i < 2; i++) begin
            m_we[i] = 1'b0;
            if (m_active[i]) begin
                if (s_valid) begin
                    m_we[i]   = 1'b1;
                    m_addr[i] = 32'(m_cnt[i] * 4);
                    m_din[i]  = s_data;
                    m_cnt[i]  = m_cnt[i] + 1;
                    if (i == 0) exp_q_big.push_back({m_addr[i], m_din[i]});
                    else        exp_q_small.push_back({m_addr[i], m_din[i]});
                    if (m_cnt[i] == m_depth[i]) begin
                        m_active[i] = 1'b0;
                        m_done[i]   = 1'b1;
                    end
                end
            end else if (fire) begin
                m_active[i] = 1'b1;
                m_done[i]   = 1'b0;
                m_cnt[i]    = 0;
            end
        end
        h2 = h1;
        h1 = h0;
        h0 = capture_trig;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_one(input string p, input int i,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] wc, input logic we,
                             input logic en, input logic bz, input logic dn);
        logic [63:0] e;
        chk({p, ".we"},    64'(we),    64'(m_we[i]));
        chk({p, ".busy"},  64'(bz),    64'(m_active[i]));
        chk({p, ".done"},  64'(dn),    64'(m_done[i]));
        chk({p, ".count"}, 64'(wc),    64'(m_cnt[i]));
        chk({p, ".addr"},  64'(a),     64'(m_addr[i]));
        chk({p, ".din"},   64'(d),     64'(m_din[i]));
        chk({p, ".en"},    64'(en),    64'd1);
        chk({p, ".excl"},  64'(bz & dn), 64'd0);
        if (we) begin
            if (i == 0 && exp_q_big.size() > 0) begin
                e = exp_q_big.pop_front();
                chk({p, ".wr"}, {a, d}, e);
            end else if (i == 1 && exp_q_small.size() > 0) begin
                e = exp_q_small.pop_front();
                chk({p, ".wr"}, {a, d}, e);
            end
        end
    endtask

    task automatic check_all();
        check_one("big",   0, addr_b, din_b, wc_b, we_b, en_b, busy_b, done_b);
        check_one("small", 1, addr_s, din_s, wc_s, we_s, en_s, busy_s, done_s);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change at the falling edge; the model runs at the rising edge on
    // those stable inputs, and outputs are compared at the next falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        @(negedge clk);
        check_all();
    endtask

    // mode 0: continuous valid, counting data
    // mode 1: valid alternating 1/0, random data
    // mode 2: random valid (75%), random data
    // mode 3: mode 2 plus occasional random trigger toggles
    task automatic run(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            case (mode)
                0: begin s_valid = 1'b1; s_data = 32'(c - 3); end
                1: begin s_valid = (c % 2 == 0); s_data = $urandom; end
                default: begin
                    s_valid = ($urandom_range(0, 3) != 0);
                    s_data  = $urandom;
                    if (mode == 3 && $urandom_range(0, 299) == 0)
                        capture_trig = ~capture_trig;
                end
            endcase
            step();
        end
    endtask

    // Reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset_mid();
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        m_depth[0]   = BIG_WORDS;
        m_depth[1]   = SMALL_WORDS;
        rst          = 1'b1;
        capture_trig = 1'b0;
        s_valid      = 1'b0;
        s_data       = 32'd0;
        model_reset();
        #1 check_all();
        step(); step(); step();
        rst = 1'b0;
        run(5, 2);

        // full capture with continuous valid, data = word index
        capture_trig = 1'b1;
        run(2060, 0);
        capture_trig = 1'b0;
        run(10, 0);

        // gapped valid
        capture_trig = 1'b1;
        run(4120, 1);
        capture_trig = 1'b0;

        // retrigger near word 100 is ignored by the running capture
        capture_trig = 1'b1;
        run(3, 0);
        capture_trig = 1'b0;
        run(100, 0);
        capture_trig = 1'b1;
        run(3, 0);
        capture_trig = 1'b0;
        run(2000, 0);

        // trigger after done, then reset near word 500
        capture_trig = 1'b1;
        run(3, 0);
        capture_trig = 1'b0;
        run(500, 0);
        async_reset_mid();
        run(20, 2);

        // trigger level held high through reset starts a capture on release
        capture_trig = 1'b1;
        run(5, 2);
        async_reset_mid();
        run(4200, 1);
        capture_trig = 1'b0;

        // random traffic and random triggers
        run(8000, 3);

        chk("big.q_left",   64'(exp_q_big.size()),   64'd0);
        chk("small.q_left", 64'(exp_q_small.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
